irq_capture: RTL and testbench

Interrupt input conditioner directly upstream of the programmable interrupt controller. It receives raw, asynchronous device interrupt lines and synchronizes each one, with optional debouncing. Each line is then either edge-latched or level-passed per bit. The result drives the controller's `intreq` bus. A per-bit clear lets the controller retire a latched edge request, and a sticky overrun flag reports edges lost while a request was still pending.

---
 rtl/irq_capture.sv | 103 ++++++++++
 tb/tb_irq_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_capture.sv
// rtl/irq_capture.sv - interrupt line conditioner: synchronizer, optional debounce (IRQ_DEBOUNCE_EN), edge/level capture
module irq_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] irq_in,
  input  logic [WIDTH-1:0] edge_mode,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] intreq,
  output logic [WIDTH-1:0] overrun
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;

  // Synchronizer shift chain; stage 0 samples the raw asynchronous lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef IRQ_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // Debounce: filt only takes the new sync level after it has differed for DEBOUNCE_CYCLES consecutive edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      filt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] != filt_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            filt_q[i] <= sync[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  logic unused_debounce_cfg;

  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign filt = sync;
`endif

  assign rise = filt & ~prev_q;

  // Previous filtered level, used to spot rising edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= filt;
  end

  // Per-bit request/overrun: level bits track filt, edge bits latch until the controller clears them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intreq  <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!edge_mode[i]) begin
          intreq[i] <= filt[i];
          if (clear[i]) overrun[i] <= 1'b0;
        end else if (rise[i] && clear[i]) begin
          // old request retired, new edge becomes the pending one
          intreq[i] <= 1'b1;
        end else if (rise[i]) begin
          intreq[i] <= 1'b1;
          if (intreq[i]) overrun[i] <= 1'b1;
        end else if (clear[i]) begin
          intreq[i]  <= 1'b0;
          overrun[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_irq_capture.sv
// tb/tb_irq_capture.sv - scoreboard testbench for irq_capture with randomized stimulus and reference model
module tb_irq_capture;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int DC = 4;
`ifdef IRQ_DEBOUNCE_EN
  localparam int PW  = DC + 1;
  localparam int LAT = S + DC + 1;
`else
  localparam int PW  = 2;
  localparam int LAT = S + 1;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] irq_in;
  logic [W-1:0] edge_mode;
  logic [W-1:0] clear;
  logic [W-1:0] intreq;
  logic [W-1:0] overrun;

  irq_capture #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .edge_mode(edge_mode),
    .clear(clear), .intreq(intreq), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] sbq [$];

  // reference model state
  logic [W-1:0] m_hist [S];
  logic [W-1:0] m_filt, m_prev, m_req, m_ovr;
  int           m_run [W];

  task automatic model_reset();
    for (int k = 0; k < S; k++) m_hist[k] = '0;
    m_filt = '0; m_prev = '0; m_req = '0; m_ovr = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  function automatic logic [W-1:0] cur_filt();
`ifdef IRQ_DEBOUNCE_EN
    return m_filt;
`else
    return m_hist[S-1];
`endif
  endfunction

  function automatic logic [W-1:0] model_rise();
    return cur_filt() & ~m_prev;
  endfunction

  task automatic model_edge(input logic [W-1:0] in, input logic [W-1:0] em, input logic [W-1:0] clr);
    logic [W-1:0] f;
    logic [W-1:0] r;
    f = cur_filt();
    r = f & ~m_prev;
    for (int i = 0; i < W; i++) begin
      if (!em[i]) begin
        m_req[i] = f[i];
        if (clr[i]) m_ovr[i] = 1'b0;
      end else if (r[i] && clr[i]) begin
        m_req[i] = 1'b1;
      end else if (r[i] && m_req[i]) begin
        m_ovr[i] = 1'b1;
      end else if (r[i]) begin
        m_req[i] = 1'b1;
      end else if (clr[i]) begin
        m_req[i] = 1'b0;
        m_ovr[i] = 1'b0;
      end
    end
    m_prev = f;
`ifdef IRQ_DEBOUNCE_EN
    for (int i = 0; i < W; i++) begin
      if (m_hist[S-1][i] != m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DC) begin
          m_filt[i] = m_hist[S-1][i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`endif
    for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = in;
    sbq.push_back({m_req, m_ovr});
  endtask

  // starts and ends on a falling edge
  task automatic cycle(input logic [W-1:0] in, input logic [W-1:0] em, input logic [W-1:0] clr);
    irq_in = in; edge_mode = em; clear = clr;
    @(posedge clk);
    model_edge(in, em, clr);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every falling edge, compare DUT outputs with the oldest expected entry
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if ({intreq, overrun} !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: intreq=%h overrun=%h expected intreq=%h overrun=%h",
                   $time, intreq, overrun, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    int first;
    bit done;
    logic [W-1:0] cin, cem, clr, seen;

    reset = 1'b1; irq_in = 8'hFF; edge_mode = 8'h00; clear = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_intreq", intreq, 8'h00);
    chk("reset_overrun", overrun, 8'h00);

    // level mode rise latency
    reset = 1'b0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle(8'hFF, 8'h00, 8'h00);
      if (first < 0 && intreq == 8'hFF) first = k;
    end
    chk_int("level_rise_latency", first, LAT);

    // level mode fall latency
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle(8'h00, 8'h00, 8'h00);
      if (first < 0 && intreq == 8'h00) first = k;
    end
    chk_int("level_fall_latency", first, LAT);

    // edge latch and clear on bit 0
    for (int k = 0; k < PW; k++) cycle(8'h01, 8'h01, 8'h00);
    repeat (12) cycle(8'h00, 8'h01, 8'h00);
    chk("edge_latched", intreq & 8'h01, 8'h01);
    chk("edge_no_overrun", overrun & 8'h01, 8'h00);
    cycle(8'h00, 8'h01, 8'h01);
    chk("edge_cleared", intreq & 8'h01, 8'h00);

    // overrun: two edges without a clear
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < PW; k++) cycle(8'h01, 8'h01, 8'h00);
      repeat (12) cycle(8'h00, 8'h01, 8'h00);
    end
    chk("overrun_intreq", intreq & 8'h01, 8'h01);
    chk("overrun_flag", overrun & 8'h01, 8'h01);
    cycle(8'h00, 8'h01, 8'h01);
    chk("overrun_clr_intreq", intreq & 8'h01, 8'h00);
    chk("overrun_clr_flag", overrun & 8'h01, 8'h00);

    // clear landing in the same cycle as a new rise, with a request already pending
    for (int k = 0; k < PW; k++) cycle(8'h01, 8'h01, 8'h00);
    repeat (12) cycle(8'h00, 8'h01, 8'h00);
    done = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cin = (j < PW) ? 8'h01 : 8'h00;
      clr = (!done && model_rise()[0]) ? 8'h01 : 8'h00;
      cycle(cin, 8'h01, clr);
      if (clr[0]) begin
        done = 1'b1;
        chk("rise_clr_intreq", intreq & 8'h01, 8'h01);
        chk("rise_clr_overrun", overrun & 8'h01, 8'h00);
      end
    end
    chk_int("rise_clr_found", int'(done), 1);
    cycle(8'h00, 8'h00, 8'hFF);
    repeat (8) cycle(8'h00, 8'h00, 8'h00);

`ifdef IRQ_DEBOUNCE_EN
    // a short glitch must not reach intreq
    seen = 8'h00;
    repeat (DC - 1) begin
      cycle(8'h02, 8'h00, 8'h00);
      seen = seen | intreq;
    end
    repeat (12) begin
      cycle(8'h00, 8'h00, 8'h00);
      seen = seen | intreq;
    end
    chk("glitch_rejected", seen & 8'h02, 8'h00);
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle(8'h02, 8'h00, 8'h00);
      if (first < 0 && intreq[1]) first = k;
    end
    chk_int("debounce_latency", first, LAT);
    repeat (12) cycle(8'h00, 8'h00, 8'h00);
`endif

    // randomized phase
    cin = 8'h00; cem = 8'h00;
    for (int n = 0; n < 600; n++) begin
      cin = cin ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 39) == 0) cem = 8'($urandom);
      clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cycle(cin, cem, clr);
    end

    // build intreq=5A / overrun=02, then reset between edges
    cycle(8'h00, 8'h00, 8'hFF);
    repeat (12) cycle(8'h00, 8'h00, 8'h00);
    repeat (12) cycle(8'h5A, 8'h02, 8'h00);
    repeat (12) cycle(8'h58, 8'h02, 8'h00);
    repeat (12) cycle(8'h5A, 8'h02, 8'h00);
    chk("pre_reset_intreq", intreq, 8'h5A);
    chk("pre_reset_overrun", overrun, 8'h02);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_intreq", intreq, 8'h00);
    chk("async_reset_overrun", overrun, 8'h00);
    @(negedge clk);
    chk_int("queue_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
